// File: rtl/clz_seq_pkg.sv
// ---------------------------------------------------------------------------
// clz_seq_pkg
//
// Shared definitions for the multicycle leading-zero/leading-one count unit:
//   - datapath widths (operand, half operand, core count, result)
//   - op encodings for CLZ / CLO
//   - FSM state encoding used by the clz_seq top level
//
// Configuration macro consumed elsewhere in this slice: CLZSEQ_CLO_EN
// (enables the CLO operand inversion in clz_seq).
// ---------------------------------------------------------------------------
package clz_seq_pkg;

  // Full operand width and the half that the shared count core evaluates.
  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  // Core count 0..16 needs 5 bits; final result 0..32 needs 6 bits.
  localparam int CNT_W  = 5;
  localparam int RES_W  = 6;

  // Operation select carried on the op port.
  localparam logic OP_CLZ = 1'b0;
  localparam logic OP_CLO = 1'b1;

  // Sequencer states: IDLE waits for start, HI counts the upper half,
  // LO counts the lower half (only when the upper half is all zero),
  // DONE presents the one-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/clz_seq_if.sv
// ---------------------------------------------------------------------------
// clz_seq_if
//
// Request/response bundle between the CPU control FSM (master) and the
// clz_seq unit (slave).
//
// Signals:
//   start  master->slave  request, sampled only while the unit is idle
//   op     master->slave  0 = CLZ, 1 = CLO, sampled with start
//   a      master->slave  32-bit operand, sampled with start
//   flush  master->slave  synchronous abort from the exception/flush path
//   busy   slave->master  high whenever the unit is not idle
//   done   slave->master  one-cycle completion pulse
//   r      slave->master  registered result 0..32, valid from done onward
// ---------------------------------------------------------------------------
interface clz_seq_if;
  import clz_seq_pkg::*;

  logic              start;
  logic              op;
  logic [DATA_W-1:0] a;
  logic              flush;
  logic              busy;
  logic              done;
  logic [RES_W-1:0]  r;

  modport master (
    output start,
    output op,
    output a,
    output flush,
    input  busy,
    input  done,
    input  r
  );

  modport slave (
    input  start,
    input  op,
    input  a,
    input  flush,
    output busy,
    output done,
    output r
  );

endinterface

// File: rtl/clz_seq_clz16_core.sv
// ---------------------------------------------------------------------------
// clz16_core
//
// Purely combinational 16-bit leading-zero counter shared by both halves
// of the clz_seq operand.
//
// Ports:
//   din  in   16  value to count
//   zc   out  5   number of leading zeros, 0..16 (all-zero input gives 16)
//
// Structure: a tree of 2-bit leaves merged pairwise. A leaf maps
// 00->2, 01->1, 1x->0. At every merge the lower count is only added when
// the upper sub-block is entirely zero (its count equals its width);
// otherwise the upper count already is the answer.
// ---------------------------------------------------------------------------
module clz16_core
  import clz_seq_pkg::*;
(
  input  logic [HALF_W-1:0] din,
  output logic [CNT_W-1:0]  zc
);

  // Index 0 of each level is the least-significant sub-block.
  logic [1:0] lvl1 [8];   // 2-bit blocks, count 0..2
  logic [2:0] lvl2 [4];   // 4-bit blocks, count 0..4
  logic [3:0] lvl3 [2];   // 8-bit blocks, count 0..8

  // Leaves.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl1[i] = 2'd0;
      if (din[2*i+1]) begin
        lvl1[i] = 2'd0;
      end else if (din[2*i]) begin
        lvl1[i] = 2'd1;
      end else begin
        lvl1[i] = 2'd2;
      end
    end
  end

  // 2-bit blocks -> 4-bit blocks.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl2[i] = {1'b0, lvl1[2*i+1]};
      if (lvl1[2*i+1] == 2'd2) begin
        lvl2[i] = 3'd2 + {1'b0, lvl1[2*i]};
      end
    end
  end

  // 4-bit blocks -> 8-bit blocks.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl3[i] = {1'b0, lvl2[2*i+1]};
      if (lvl2[2*i+1] == 3'd4) begin
        lvl3[i] = 4'd4 + {1'b0, lvl2[2*i]};
      end
    end
  end

  // 8-bit blocks -> full 16-bit count.
  always_comb begin
    zc = {1'b0, lvl3[1]};
    if (lvl3[1] == 4'd8) begin
      zc = 5'd8 + {1'b0, lvl3[0]};
    end
  end

endmodule

// File: rtl/clz_seq.sv
// ---------------------------------------------------------------------------
// clz_seq
//
// Multicycle CLZ/CLO unit. One 16-bit count core is time-shared over the
// upper half (state HI) and, only when that half is all zero, the lower
// half (state LO) of a latched 32-bit operand.
//
// Ports:
//   clk    in      core clock, rising edge
//   rst_n  in      asynchronous active-low reset
//   bus    slave   clz_seq_if: start/op/a/flush in, busy/done/r out
//
// Latency from the accepting edge: 2 cycles to done when the upper half
// contains a one, 3 cycles when it is all zero. busy/done are pure state
// decodes and r is a register, so no input reaches an output
// combinationally.
//
// Configuration: CLZSEQ_CLO_EN
//   defined   - op=1 inverts the operand when it is latched (CLO)
//   undefined - op is ignored and every request is a CLZ
// ---------------------------------------------------------------------------
module clz_seq
  import clz_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  clz_seq_if.slave   bus
);

  localparam logic [CNT_W-1:0] HALF_FULL = CNT_W'(HALF_W);

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] opnd;      // operand as counted (already inverted for CLO)
  logic [DATA_W-1:0] opnd_in;
  logic [CNT_W-1:0]  cnt;       // upper-half count captured in HI
  logic [RES_W-1:0]  r_q;

  logic [HALF_W-1:0] half;      // core input
  logic [CNT_W-1:0]  zc;        // core output

  logic              accept;

  // Operand conditioning at latch time: counting leading ones of a is the
  // same as counting leading zeros of ~a.
`ifdef CLZSEQ_CLO_EN
  assign opnd_in = (bus.op == OP_CLO) ? ~bus.a : bus.a;
`else
  assign opnd_in = bus.a;
`endif

  assign accept = (state == IDLE) && bus.start && !bus.flush;

  // Half-select mux; the core is idle (fed zero) outside HI/LO.
  always_comb begin
    half = '0;
    case (state)
      HI:      half = opnd[DATA_W-1:HALF_W];
      LO:      half = opnd[HALF_W-1:0];
      default: half = '0;
    endcase
  end

  clz16_core u_core (
    .din (half),
    .zc  (zc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = HI;
        HI:      state_nxt = (zc == HALF_FULL) ? LO : DONE;
        LO:      state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand, partial count and result registers. r is only written on the
  // transition into DONE, so it holds the previous result through IDLE and
  // the whole next operation, and a flushed operation never touches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd <= '0;
      cnt  <= '0;
      r_q  <= '0;
    end else begin
      if (accept) begin
        opnd <= opnd_in;
      end
      if (state == HI) begin
        cnt <= zc;
      end
      if (!bus.flush) begin
        if ((state == HI) && (zc != HALF_FULL)) begin
          r_q <= {1'b0, zc};
        end else if (state == LO) begin
          // cnt is 16 here: the upper half was all zero.
          r_q <= {1'b0, cnt} + {1'b0, zc};
        end
      end
    end
  end

  // Moore outputs.
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.r    = r_q;

endmodule

// File: tb/tb_clz_seq.sv
module tb_clz_seq;
  import clz_seq_pkg::*;

  logic clk;
  logic rst_n;

  clz_seq_if bus ();

  clz_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [5:0]  exp_r;
    int          exp_lat;
  } vec_t;

  vec_t vecs [13];

  logic [31:0] a_seq [14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Leading-zero reference, scanned bit by bit from the MSB.
  function automatic int ref_clz(input logic [31:0] v);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) seen = 1'b1;
      if (!seen) n++;
    end
    return n;
  endfunction

  task automatic run_op(input string name, input logic op, input logic [31:0] a,
                        input logic [5:0] exp_r, input int exp_lat);
    int lat;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    tick;
    bus.start = 1'b0;
    bus.a     = ~a;   // operand need not be held after acceptance
    lat = 1;
    while (bus.done !== 1'b1 && lat < 8) begin
      tick;
      lat++;
    end
    check({name, " done seen"}, {31'd0, bus.done}, 32'd1);
    check({name, " latency"}, lat, exp_lat);
    check({name, " r"}, {26'd0, bus.r}, {26'd0, exp_r});
    check({name, " busy with done"}, {31'd0, bus.busy}, 32'd1);
    tick;
    check({name, " done one cycle"}, {31'd0, bus.done}, 32'd0);
    check({name, " busy after"}, {31'd0, bus.busy}, 32'd0);
    check({name, " r held"}, {26'd0, bus.r}, {26'd0, exp_r});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_at;
    int done_edge;
    logic [5:0] exp_val;
    int L;

    vecs[0]  = '{OP_CLZ, 32'h0001_0000, 6'd15, 2};
    vecs[1]  = '{OP_CLZ, 32'h0000_8000, 6'd16, 3};
    vecs[2]  = '{OP_CLZ, 32'h0000_0000, 6'd32, 3};
    vecs[3]  = '{OP_CLZ, 32'h8000_0000, 6'd0,  2};
    vecs[4]  = '{OP_CLZ, 32'h0000_0001, 6'd31, 3};
    vecs[5]  = '{OP_CLZ, 32'h0123_4567, 6'd7,  2};
    vecs[6]  = '{OP_CLZ, 32'h0000_7FFF, 6'd17, 3};
    vecs[7]  = '{OP_CLZ, 32'h0020_0000, 6'd10, 2};
`ifdef CLZSEQ_CLO_EN
    vecs[8]  = '{OP_CLO, 32'hFFF0_0000, 6'd12, 2};
    vecs[9]  = '{OP_CLO, 32'hFFFF_FFFF, 6'd32, 3};
    vecs[10] = '{OP_CLO, 32'h7FFF_FFFF, 6'd0,  2};
    vecs[11] = '{OP_CLO, 32'hFFFF_0000, 6'd16, 3};
    vecs[12] = '{OP_CLO, 32'h0000_0000, 6'd0,  2};
`else
    vecs[8]  = '{OP_CLO, 32'hFFF0_0000, 6'd0,  2};
    vecs[9]  = '{OP_CLO, 32'hFFFF_FFFF, 6'd0,  2};
    vecs[10] = '{OP_CLO, 32'h7FFF_FFFF, 6'd1,  2};
    vecs[11] = '{OP_CLO, 32'hFFFF_0000, 6'd0,  2};
    vecs[12] = '{OP_CLO, 32'h0000_0000, 6'd32, 3};
`endif

    a_seq = '{32'h0001_0000, 32'h8000_0000, 32'h0000_0100, 32'h0000_0001,
              32'h4000_0000, 32'h0000_FFFF, 32'h0000_0000, 32'h1234_5678,
              32'h0000_0002, 32'h0080_0000, 32'h0000_0000, 32'h0000_4000,
              32'h2000_0000, 32'h0000_0008};

    // Reset state
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_CLZ;
    bus.a     = '0;
    bus.flush = 1'b0;
    tick;
    tick;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset r", {26'd0, bus.r}, 32'd0);
    rst_n = 1'b1;
    tick;
    check("post-reset busy", {31'd0, bus.busy}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].exp_r, vecs[i].exp_lat);
    end

    // start held high with a changing every cycle: only IDLE-time starts count
    idle_at   = 0;
    done_edge = -1;
    exp_val   = '0;
    for (int k = 0; k < 22; k++) begin
      bus.start = (k < 14);
      bus.op    = OP_CLZ;
      bus.a     = (k < 14) ? a_seq[k] : 32'hFFFF_FFFF;
      if ((k < 14) && (k >= idle_at)) begin
        exp_val   = 6'(ref_clz(a_seq[k]));
        L         = (a_seq[k][31:16] == 16'd0) ? 3 : 2;
        done_edge = k + L - 1;
        idle_at   = k + L + 1;
      end
      tick;
      check($sformatf("held k=%0d done", k), {31'd0, bus.done}, {31'd0, (k == done_edge)});
      check($sformatf("held k=%0d busy", k), {31'd0, bus.busy}, {31'd0, (k <= done_edge)});
      if (k == done_edge) begin
        check($sformatf("held k=%0d r", k), {26'd0, bus.r}, {26'd0, exp_val});
      end
    end
    bus.start = 1'b0;

    // start together with flush in IDLE is dropped
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.a     = 32'h0001_0000;
    tick;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("start+flush dropped busy", {31'd0, bus.busy}, 32'd0);
    tick;
    check("start+flush dropped done", {31'd0, bus.done}, 32'd0);

    // Flush in LO leaves r untouched
    run_op("pre-flush r=7", OP_CLZ, 32'h0100_0000, 6'd7, 2);
    bus.start = 1'b1;
    bus.op    = OP_CLZ;
    bus.a     = 32'h0000_0001;
    tick;                     // accepted, now HI
    bus.start = 1'b0;
    tick;                     // upper half zero, now LO
    check("flush pre busy", {31'd0, bus.busy}, 32'd1);
    check("flush pre done", {31'd0, bus.done}, 32'd0);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    check("flush busy", {31'd0, bus.busy}, 32'd0);
    check("flush done", {31'd0, bus.done}, 32'd0);
    check("flush r kept", {26'd0, bus.r}, 32'd7);
    tick;
    check("flush no late done", {31'd0, bus.done}, 32'd0);
    check("flush r still kept", {26'd0, bus.r}, 32'd7);
    run_op("after flush", OP_CLZ, 32'h0000_0010, 6'd27, 3);

    // Asynchronous reset while in HI
    bus.start = 1'b1;
    bus.op    = OP_CLZ;
    bus.a     = 32'h0001_0000;
    tick;
    bus.start = 1'b0;
    check("mid-op busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset busy", {31'd0, bus.busy}, 32'd0);
    check("async reset done", {31'd0, bus.done}, 32'd0);
    check("async reset r", {26'd0, bus.r}, 32'd0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check($sformatf("after reset k=%0d done", k), {31'd0, bus.done}, 32'd0);
      check($sformatf("after reset k=%0d busy", k), {31'd0, bus.busy}, 32'd0);
    end
    run_op("recover", OP_CLZ, 32'h0000_0400, 6'd21, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clz_seq.md
# clz_seq

Multicycle leading-zero/leading-one count unit for the 54-instruction multicycle CPU. It executes CLZ and CLO by time-sharing one 16-bit count core over the two halves of a 32-bit operand. The main control FSM sequences it with a start/done handshake during its EXE stage, and it can be aborted by the CPU's exception/flush path. The result goes to the register-file write-back mux.

## Interface
- No parameters; widths are fixed by the package (data 32, result 6).
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = CLZ, 1 = CLO; sampled with start
- a  in  32  operand; sampled with start, need not be held afterwards
- flush  in  1  synchronous abort (exception/pipeline kill)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- r  out  6  result 0..32; registered, valid from done onward

## Operation
- States: IDLE, HI, LO, DONE.
- IDLE:
  - When start=1 and flush=0, latch opnd = op ? ~a : a, then go to HI.
  - start with flush=1 is dropped.
- HI:
  - The core evaluates opnd[31:16] and the result is latched as cnt (5 bits).
  - If cnt==16, go to LO. Otherwise set r = {1'b0, cnt} and go to DONE.
- LO:
  - The core evaluates opnd[15:0]: zl.
  - Set r = 16 + zl (6-bit add, maximum 32) and go to DONE.
- DONE:
  - done=1 for this cycle only, then go to IDLE.
- The core input mux selects opnd[31:16] in HI and opnd[15:0] in LO. The core is never used in IDLE or DONE.
- start outside IDLE is ignored and never queued.
- Results:
  - a=0 gives r=32.
  - a=0xFFFFFFFF with CLO gives r=32.
  - Bit 31 set with CLZ gives r=0.
- flush=1 in any state:
  - Next state is IDLE; flush has priority over every other transition.
  - done is not asserted on the following cycle, and r is not written.
  - flush in DONE does not suppress that cycle's done, because done is a decode of the current state.
- r is written only on entry to DONE. It holds its value through IDLE and through the next operation until that operation completes.
- Reset values: state=IDLE, busy=0, done=0, r=0, opnd=0, cnt=0.
- Asserting reset mid-operation abandons the operation silently, with outputs at their reset values.

## Timing
- start is sampled at edge E0.
- Upper half non-zero: busy is high from E0 to E2 and done is high in the cycle after E1, i.e. 2 cycles of latency.
- Upper half zero: LO is the cycle after E1 and done is high in the cycle after E2, i.e. 3 cycles of latency.
- r is valid in the same cycle done is high.
- done and busy are Moore outputs; done=1 implies busy=1.
- Minimum spacing between accepted starts: 3 cycles (HI→DONE→IDLE) or 4 cycles (via LO).
- No combinational path from any input to any output.

## Configuration
- CLZSEQ_CLO_EN:
  - Defined: op=1 inverts the operand at latch time, giving CLO.
  - Undefined: op is ignored and every request is CLZ. The port remains so instantiations do not change.
- Latency is identical in both builds.

## Structure
- Package clz_seq_pkg holds:
  - the state enum (IDLE, HI, LO, DONE)
  - DATA_W=32, HALF_W=16, RES_W=6
  - op encodings OP_CLZ=1'b0, OP_CLO=1'b1
- Sub-module clz16_core: purely combinational.
  - 16-bit input, 5-bit leading-zero count 0..16 (all-zero input gives 16).
  - Built as a 2-bit leaf tree: a leaf maps 00→2, 01→1, 1x→0. Each merge computes upper + lower when the upper half is all-zero, else upper.
  - No enable or tri-state.
- The top level holds the FSM, opnd/cnt/r registers and the half-select mux.

## Test plan
- CLZ, a=0x0001_0000 → done 2 cycles after start, r=15; busy low the cycle after done.
- CLZ, a=0x0000_8000 → done 3 cycles after start (LO visited), r=16. CLZ, a=0 → r=32 at 3 cycles.
- CLO with macro: a=0xFFF0_0000 → r=12; a=0xFFFF_FFFF → r=32 at 3 cycles. Without macro: same stimuli → r=0.
- start held high continuously with changing a → only starts seen in IDLE are taken; each result matches the operand latched at acceptance.
- Complete with r=7, then start a=0x0000_0001 and assert flush in LO → no done, r stays 7, busy=0 next cycle, next start accepted normally.
- rst_n low for one cycle in HI → busy=0, done=0, r=0 immediately; no done follows.
